y_signature_misr: RTL

//  Downstream result compactor for the fuzz harness: consumes the 425-bit DUT output bus y

---
 rtl/y_signature_misr.sv | 130 +++++++++++++
 1 files changed

// File: rtl/y_signature_misr.sv
// Result compactor: XOR-folds the wide DUT output bus and absorbs it into a MISR.
// After NUM_VECTORS samples it freezes the signature and compares it against a golden value.
module y_signature_misr #(
  parameter int unsigned          Y_WIDTH     = 425,
  parameter int unsigned          SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED        = 32'hFFFFFFFF,
  parameter int unsigned          NUM_VECTORS = 22
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               y_valid,
  input  logic [Y_WIDTH-1:0]                 y,
  input  logic [SIG_WIDTH-1:0]               expected_sig,
  output logic                               busy,
  output logic                               done,
  output logic                               match,
  output logic [SIG_WIDTH-1:0]               signature,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   sample_count
);

  localparam int unsigned CNT_W      = $clog2(NUM_VECTORS + 1);
  localparam int unsigned NUM_CHUNKS = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int unsigned PAD_W      = NUM_CHUNKS * SIG_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     accept_cnt;
  logic [SIG_WIDTH-1:0] fold_q;
  logic                 fold_v;

  logic                 load_seed_c;
  logic                 accept_c;
  logic                 absorb_c;
  logic [PAD_W-1:0]     y_pad_c;
  logic [SIG_WIDTH-1:0] fold_c;
  logic [SIG_WIDTH-1:0] misr_nx_c;

  // Zero-extend y to a whole number of chunks so the fold needs no bounds checks.
  assign y_pad_c = PAD_W'(y);

  always_comb begin
    fold_c = '0;
    for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
      fold_c = fold_c ^ y_pad_c[k*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign misr_nx_c = {signature[SIG_WIDTH-2:0], 1'b0}
                   ^ (signature[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold_q;

  assign match = done && (signature == expected_sig);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the per-cycle load/accept/absorb strobes; abort always wins.
  always_comb begin
    state_nx    = state;
    load_seed_c = 1'b0;
    accept_c    = 1'b0;
    absorb_c    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (start) begin
          state_nx    = S_CAPTURE;
          load_seed_c = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else begin
          accept_c = y_valid && (accept_cnt < CNT_W'(NUM_VECTORS));
          absorb_c = fold_v;
          if (fold_v && (sample_count == CNT_W'(NUM_VECTORS - 1))) begin
            state_nx = S_DONE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Two-stage datapath: fold register, then MISR absorb one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      signature    <= '0;
      sample_count <= '0;
      accept_cnt   <= '0;
      fold_q       <= '0;
      fold_v       <= 1'b0;
    end else begin
      busy   <= (state_nx == S_CAPTURE);
      done   <= (state_nx == S_DONE);
      fold_v <= accept_c;
      if (accept_c) begin
        fold_q     <= fold_c;
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
      if (load_seed_c) begin
        signature    <= SEED;
        sample_count <= '0;
        accept_cnt   <= '0;
      end else if (absorb_c) begin
        signature    <= misr_nx_c;
        sample_count <= sample_count + CNT_W'(1);
      end
    end
  end

endmodule
